// File: rtl/tlb_op_ctrl.sv
// MEM1-stage sequencer for TLBP/TLBR/TLBWI/TLBWR: drives TLB strobes, CP0
// write-back and the address/entry muxes, and owns the CP0 Random counter.
module tlb_op_ctrl #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tlbp_req,
  input  logic             tlbr_req,
  input  logic             tlbwi_req,
  input  logic             tlbwr_req,
  input  logic             flush,
  input  logic [IDX_W-1:0] cp0_index,
  input  logic [IDX_W-1:0] cp0_wired,
  input  logic             wired_we,
  input  logic             lookup_hit,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             busy,
  output logic             MUX11_Sel,
  output logic             MUX12_Sel,
  output logic             lookup_en,
  output logic             tlb_re,
  output logic             tlb_we,
  output logic             index_we,
  output logic [31:0]      index_wdata,
  output logic             entry_we,
  output logic [IDX_W-1:0] random
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROBE,
    S_PROBE_WB,
    S_READ,
    S_READ_WB,
    S_WRITE
  } state_e;

  localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(TLB_ENTRIES - 1);

  state_e           state_q, state_d;
  logic             wr_idx_q, wr_idx_d;   // 1 = TLBWI (Index), 0 = TLBWR (Random)
  logic [IDX_W-1:0] random_q, random_d;
  logic [IDX_W-1:0] probe_idx;

  // The entry address comes straight from CP0 Index through MUX12 outside
  // this block; the port is kept so the controller sees the full CP0 view.
  logic unused_index;
  assign unused_index = ^cp0_index;

  // NOTE: reset is synchronous and active-high, so it lives inside the
  // clocked branch; state only, there is no storage array to clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_idx_q <= 1'b0;
      random_q <= RAND_MAX;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      random_q <= random_d;
    end
  end

  assign probe_idx = lookup_hit ? lookup_idx : '0;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    busy        = 1'b0;
    MUX11_Sel   = 1'b0;
    MUX12_Sel   = 1'b0;
    lookup_en   = 1'b0;
    tlb_re      = 1'b0;
    tlb_we      = 1'b0;
    index_we    = 1'b0;
    index_wdata = '0;
    entry_we    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!flush) begin
          if (tlbp_req) begin
            state_d = S_PROBE;
            busy    = 1'b1;
          end else if (tlbr_req) begin
            state_d = S_READ;
            busy    = 1'b1;
          end else if (tlbwi_req) begin
            state_d  = S_WRITE;
            wr_idx_d = 1'b1;
            busy     = 1'b1;
          end else if (tlbwr_req) begin
            state_d  = S_WRITE;
            wr_idx_d = 1'b0;
            busy     = 1'b1;
          end
        end
      end
      S_PROBE: begin
        busy      = 1'b1;
        lookup_en = 1'b1;
        MUX11_Sel = 1'b1;
        state_d   = S_PROBE_WB;
      end
      S_PROBE_WB: begin
        // Index.P (bit 31) flags a miss; the index field is zero on a miss.
        index_we    = 1'b1;
        index_wdata = {~lookup_hit, {(31 - IDX_W){1'b0}}, probe_idx};
        state_d     = S_IDLE;
      end
      S_READ: begin
        busy      = 1'b1;
        tlb_re    = 1'b1;
        MUX12_Sel = 1'b1;
        state_d   = S_READ_WB;
      end
      S_READ_WB: begin
        entry_we  = 1'b1;
        MUX12_Sel = 1'b1;
        state_d   = S_IDLE;
      end
      S_WRITE: begin
        tlb_we    = 1'b1;
        MUX12_Sel = wr_idx_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Random freezes while busy so a TLBWR writes the slot seen at acceptance.
  always_comb begin
    random_d = random_q;
    if (wired_we) begin
      random_d = RAND_MAX;
    end else if (!busy) begin
      if (cp0_wired >= RAND_MAX || random_q == cp0_wired)
        random_d = RAND_MAX;
      else
        random_d = random_q - IDX_W'(1);
    end
  end

  assign random = random_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_tlb_op_ctrl;

  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tlbp_req = 1'b0, tlbr_req = 1'b0, tlbwi_req = 1'b0, tlbwr_req = 1'b0;
  logic             flush = 1'b0, wired_we = 1'b0, lookup_hit = 1'b0;
  logic [IDX_W-1:0] cp0_index = '0, cp0_wired = '0, lookup_idx = '0;
  logic             busy, MUX11_Sel, MUX12_Sel, lookup_en, tlb_re, tlb_we, index_we, entry_we;
  logic [31:0]      index_wdata;
  logic [IDX_W-1:0] random;

  always #5 clk = ~clk;

  tlb_op_ctrl #(.TLB_ENTRIES(16), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .tlbp_req(tlbp_req), .tlbr_req(tlbr_req), .tlbwi_req(tlbwi_req), .tlbwr_req(tlbwr_req),
    .flush(flush), .cp0_index(cp0_index), .cp0_wired(cp0_wired), .wired_we(wired_we),
    .lookup_hit(lookup_hit), .lookup_idx(lookup_idx),
    .busy(busy), .MUX11_Sel(MUX11_Sel), .MUX12_Sel(MUX12_Sel), .lookup_en(lookup_en),
    .tlb_re(tlb_re), .tlb_we(tlb_we), .index_we(index_we), .index_wdata(index_wdata),
    .entry_we(entry_we), .random(random)
  );

  typedef struct {
    string       name;
    logic [43:0] v;   // {busy,m11,m12,lookup_en,re,we,index_we,entry_we,wdata[31:0],random[3:0]}
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0, failures = 0, pushed = 0, popped = 0;

  wire [43:0] obs = {busy, MUX11_Sel, MUX12_Sel, lookup_en, tlb_re, tlb_we,
                     index_we, entry_we, index_wdata, random};

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: {busy,m11,m12,lk,re,we,iwe,ewe,wdata,rnd} got %h expected %h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      popped++;
      check(mon_e.name, obs, mon_e.v);
    end
  end

  task automatic step(input string name, input logic [3:0] rnd,
                      input logic b, m11, m12, lk, re, we, iwe, ewe,
                      input logic [31:0] iwd);
    exp_t e;
    e.name = name;
    e.v    = {b, m11, m12, lk, re, we, iwe, ewe, iwd, rnd};
    sb_q.push_back(e);
    pushed++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name, input logic [3:0] rnd);
    step(name, rnd, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    idle("reset", 4'd15);
    rst = 1'b0;

    // Free-running count with Wired = 0, wrapping through 0 back to 15.
    for (int i = 0; i < 20; i++) idle("count_w0", 4'(15 - i));
    for (int i = 11; i > 4; i--) idle("count_w0", 4'(i));

    // Wired = 10 written while Random = 4.
    cp0_wired = 4'd10; wired_we = 1'b1;
    idle("wired_we", 4'd4);
    wired_we = 1'b0;
    idle("wired_force", 4'd15);
    for (int i = 14; i >= 10; i--) idle("count_w10", 4'(i));
    idle("wrap_w10", 4'd15);

    // Wired at the top entry pins Random to 15.
    cp0_wired = 4'd15; wired_we = 1'b1;
    idle("wired15", 4'd14);
    wired_we = 1'b0;
    repeat (3) idle("hold_w15", 4'd15);
    cp0_wired = 4'd0; wired_we = 1'b1;
    idle("wired0", 4'd15);
    wired_we = 1'b0;

    // TLBP hit; a TLBWI presented during the probe must be ignored.
    tlbp_req = 1'b1;
    step("tlbp_acc", 4'd15, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    tlbp_req = 1'b0; tlbwi_req = 1'b1;
    step("probe", 4'd15, 1, 1, 0, 1, 0, 0, 0, 0, 32'h0);
    lookup_hit = 1'b1; lookup_idx = 4'd7;
    step("probe_wb_hit", 4'd15, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0000_0007);
    tlbwi_req = 1'b0; lookup_hit = 1'b0;
    idle("post_probe", 4'd14);

    // TLBP miss.
    tlbp_req = 1'b1;
    step("tlbp_miss_acc", 4'd13, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    tlbp_req = 1'b0;
    step("probe_miss", 4'd13, 1, 1, 0, 1, 0, 0, 0, 0, 32'h0);
    lookup_hit = 1'b0; lookup_idx = 4'd5;
    step("probe_wb_miss", 4'd13, 0, 0, 0, 0, 0, 0, 1, 0, 32'h8000_0000);
    idle("pre_wr", 4'd12);
    idle("pre_wr", 4'd11);
    idle("pre_wr", 4'd10);

    // TLBWR accepted at Random = 9.
    tlbwr_req = 1'b1;
    step("tlbwr_acc", 4'd9, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    tlbwr_req = 1'b0;
    step("tlbwr_write", 4'd9, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0);
    idle("post_wr", 4'd8);

    // TLBWI.
    tlbwi_req = 1'b1;
    step("tlbwi_acc", 4'd7, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    tlbwi_req = 1'b0;
    step("tlbwi_write", 4'd7, 0, 0, 1, 0, 0, 1, 0, 0, 32'h0);

    // TLBR.
    tlbr_req = 1'b1;
    step("tlbr_acc", 4'd6, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    tlbr_req = 1'b0;
    step("tlbr_read", 4'd6, 1, 0, 1, 0, 1, 0, 0, 0, 32'h0);
    step("tlbr_wb", 4'd6, 0, 0, 1, 0, 0, 0, 0, 1, 32'h0);
    idle("post_rd", 4'd5);

    // Priority: TLBP beats TLBWI.
    tlbp_req = 1'b1; tlbwi_req = 1'b1;
    step("prio_p_wi_acc", 4'd4, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    tlbp_req = 1'b0; tlbwi_req = 1'b0;
    step("prio_probe", 4'd4, 1, 1, 0, 1, 0, 0, 0, 0, 32'h0);
    lookup_hit = 1'b1; lookup_idx = 4'd15;
    step("prio_probe_wb", 4'd4, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0000_000F);
    lookup_hit = 1'b0;
    idle("post_prio", 4'd3);

    // Priority: TLBWI beats TLBWR, so the Index mux is selected.
    tlbwi_req = 1'b1; tlbwr_req = 1'b1;
    step("prio_wi_wr_acc", 4'd2, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    tlbwi_req = 1'b0; tlbwr_req = 1'b0;
    step("prio_wi_write", 4'd2, 0, 0, 1, 0, 0, 1, 0, 0, 32'h0);

    // Flush blocks acceptance.
    flush = 1'b1; tlbr_req = 1'b1;
    idle("flush_block", 4'd1);
    flush = 1'b0; tlbr_req = 1'b0;
    idle("no_read", 4'd0);

    // Reset in READ: back to IDLE with no write-back.
    tlbr_req = 1'b1;
    step("rst_tlbr_acc", 4'd15, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    tlbr_req = 1'b0; rst = 1'b1;
    step("rst_in_read", 4'd15, 1, 0, 1, 0, 1, 0, 0, 0, 32'h0);
    rst = 1'b0;
    idle("after_rst", 4'd15);
    idle("after_rst", 4'd14);

    // Flush after acceptance has no effect.
    tlbr_req = 1'b1;
    step("late_flush_acc", 4'd13, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    tlbr_req = 1'b0; flush = 1'b1;
    step("late_flush_read", 4'd13, 1, 0, 1, 0, 1, 0, 0, 0, 32'h0);
    flush = 1'b0;
    step("late_flush_wb", 4'd13, 0, 0, 1, 0, 0, 0, 0, 1, 32'h0);
    idle("final", 4'd12);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    checks++;
    if (popped != pushed) begin
      failures++;
      $display("FAIL drain: compared %0d expected %0d", popped, pushed);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
